// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_t;
    typedef enum logic {PORT_IF, PORT_DM} port_t;
    localparam logic [127:0] FETCH_BE = '1;
endpackage

// File: rtl/mem_arb_watchdog.sv
// mem_arb_watchdog: counts cycles spent waiting on memory and flags the last allowed one
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_cnt;
    // count busy cycles from zero after each grant
    always_ff @(posedge clk) begin
        if (rst || i_clear) r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
    end
    assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                    i_if_kill,
    output logic                    o_if_ready,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_dm_req,
    input  logic                    i_dm_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_be,
    output logic                    o_dm_ready,
    output logic [DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic                    o_stall_if,
    output logic                    o_stall_mem,
    output logic                    o_mem_err
);
    localparam int BW = DATA_WIDTH / 8;
    arb_state_t r_state, w_next;
    port_t      r_last;
    logic       r_drop, r_we, r_err, r_if_ready, r_dm_ready;
    logic [DATA_WIDTH-1:0] r_if_rdata, r_dm_rdata;
    logic w_idle, w_busy_if, w_busy_dm, w_expired, w_done, w_drop_now;
    logic w_if_pend, w_dm_pend, w_grant_if, w_grant_dm;
    assign w_idle     = r_state == IDLE;
    assign w_busy_if  = r_state == BUSY_IF;
    assign w_busy_dm  = r_state == BUSY_DM;
    assign w_done     = !w_idle && (i_mem_rvalid || w_expired);
    assign w_drop_now = r_drop || i_if_kill;
    // a side whose ready is pulsing has been served and must not be re-granted
    assign w_if_pend  = i_if_req && !r_if_ready && !i_if_kill;
    assign w_dm_pend  = i_dm_req && !r_dm_ready;
    assign w_grant_dm = w_idle && w_dm_pend && (!w_if_pend || r_last == PORT_IF);
    assign w_grant_if = w_idle && w_if_pend && !w_grant_dm;
    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_idle),
        .i_enable (!w_idle),
        .o_expired(w_expired)
    );
    // next state: arbitrate in IDLE, return to IDLE on response or timeout
    always_comb begin
        w_next = r_state;
        if (w_idle) w_next = w_grant_dm ? BUSY_DM : (w_grant_if ? BUSY_IF : IDLE);
        else if (w_done) w_next = IDLE;
    end
    // state, round-robin history, kill tracking, response capture and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= PORT_IF;
            r_drop     <= 1'b0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_state    <= w_next;
            r_drop     <= w_busy_if && !w_done && w_drop_now;
            r_if_ready <= w_busy_if && w_done && !w_drop_now;
            r_dm_ready <= w_busy_dm && w_done;
            if (w_grant_dm) r_we <= i_dm_we;
            if (w_done) r_last <= w_busy_if ? PORT_IF : PORT_DM;
            if (w_done && !i_mem_rvalid) r_err <= 1'b1;
            if (w_busy_if && i_mem_rvalid && !w_drop_now) r_if_rdata <= i_mem_rdata;
            if (w_busy_dm && i_mem_rvalid && !r_we) r_dm_rdata <= i_mem_rdata;
        end
    end
    assign o_mem_req   = w_grant_if || w_grant_dm;
    assign o_mem_we    = w_grant_dm && i_dm_we;
    assign o_mem_addr  = w_grant_dm ? i_dm_addr : (w_grant_if ? i_if_addr : '0);
    assign o_mem_wdata = w_grant_dm ? i_dm_wdata : '0;
    assign o_mem_be    = w_grant_dm ? i_dm_be : (w_grant_if ? FETCH_BE[BW-1:0] : '0);
    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_ready  = r_dm_ready;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_stall_if  = i_if_req && !r_if_ready;
    assign o_stall_mem = i_dm_req && !r_dm_ready;
    assign o_mem_err   = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario checks of the memory port arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_kill, if_ready, dm_req, dm_we, dm_ready;
    logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be, mem_be;
    logic        mem_req, mem_we, mem_rvalid, stall_if, stall_mem, mem_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_if, exp_dm;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
        .o_if_ready(if_ready), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_be(dm_be),
        .o_dm_ready(dm_ready), .o_dm_rdata(dm_rdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_stall_if(stall_if), .o_stall_mem(stall_mem), .o_mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        if_req = 0; if_kill = 0; if_addr = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;
        mem_rvalid = 0; mem_rdata = 0;
        step; step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        settle;
        n_chk++; if (if_ready !== 1'b0) $display("FAIL reset_if_ready: got %0h want 0", if_ready); else n_pass++;
        n_chk++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else n_pass++;
        n_chk++; if (dm_ready !== 1'b0) $display("FAIL reset_dm_ready: got %0h want 0", dm_ready); else n_pass++;
        n_chk++; if (dm_rdata !== 32'h0) $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); else n_pass++;
        n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 70'h0)
            $display("FAIL reset_mem_outputs: got req=%0h we=%0h addr=%h wdata=%h be=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata, mem_be); else n_pass++;
        n_chk++; if ({stall_if, stall_mem, mem_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {stall_if, stall_mem, mem_err}); else n_pass++;
        step;
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h100;
        settle;
        n_chk++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) $display("FAIL fetch_issue: got req=%0h we=%0h be=%h want 1 0 f", mem_req, mem_we, mem_be); else n_pass++;
        n_chk++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr: got %h want 00000100", mem_addr); else n_pass++;
        n_chk++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_t0: got %0h want 1", stall_if); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        settle;
        n_chk++; if ({mem_req, if_ready, stall_if} !== 3'b001) $display("FAIL fetch_t1: got req/ready/stall=%b want 001", {mem_req, if_ready, stall_if}); else n_pass++;
        step;
        mem_rvalid = 0; mem_rdata = 0;
        settle;
        n_chk++; if (if_ready !== 1'b1) $display("FAIL fetch_ready_t2: got %0h want 1", if_ready); else n_pass++;
        n_chk++; if (if_rdata !== 32'h00500093) $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); else n_pass++;
        n_chk++; if ({stall_if, mem_req} !== 2'b00) $display("FAIL fetch_t2_no_reissue: got stall/req=%b want 00", {stall_if, mem_req}); else n_pass++;
        if_req = 0;
        step;
        settle;
        n_chk++; if (if_ready !== 1'b0) $display("FAIL fetch_ready_pulse: got %0h want 0", if_ready); else n_pass++;
        exp_if = 32'h00500093;
    endtask

    task automatic test_tie;
        do_reset;
        step;
        if_req = 1; if_addr = 32'h300;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_be = 4'hF;
        settle;
        n_chk++; if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h2000) $display("FAIL tie1_dm_first: got req=%0h we=%0h addr=%h want 1 0 00002000", mem_req, mem_we, mem_addr); else n_pass++;
        n_chk++; if ({stall_if, stall_mem} !== 2'b11) $display("FAIL tie1_stalls: got %b want 11", {stall_if, stall_mem}); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h11111111) $display("FAIL tie1_load: got ready=%0h rdata=%h want 1 11111111", dm_ready, dm_rdata); else n_pass++;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) $display("FAIL tie1_if_next: got req=%0h addr=%h want 1 00000300", mem_req, mem_addr); else n_pass++;
        dm_req = 0;
        step;
        mem_rvalid = 1; mem_rdata = 32'h22222222;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (if_ready !== 1'b1 || if_rdata !== 32'h22222222) $display("FAIL tie1_fetch: got ready=%0h rdata=%h want 1 22222222", if_ready, if_rdata); else n_pass++;
        if_req = 0;
        step;
        if_req = 1; if_addr = 32'h304; dm_req = 1; dm_addr = 32'h2008;
        settle;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h2008) $display("FAIL tie2_dm: got req=%0h addr=%h want 1 00002008", mem_req, mem_addr); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h33333333;
        step;
        mem_rvalid = 0; dm_req = 0; if_req = 0;
        step;
        if_req = 1; if_addr = 32'h308; dm_req = 1; dm_addr = 32'h200C;
        settle;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h308) $display("FAIL tie3_if: got req=%0h addr=%h want 1 00000308", mem_req, mem_addr); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h44444444;
        step;
        mem_rvalid = 0; if_req = 0;
        settle;
        n_chk++; if (mem_addr !== 32'h200C) $display("FAIL tie3_dm_after: got %h want 0000200c", mem_addr); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h55555555;
        step;
        mem_rvalid = 0; dm_req = 0;
        step;
        exp_if = 32'h44444444; exp_dm = 32'h55555555;
    endtask

    task automatic test_store;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'hDEADBEEF; dm_be = 4'b0011;
        settle;
        n_chk++; if ({mem_req, mem_we, mem_be} !== 6'b11_0011) $display("FAIL store_ctl: got req=%0h we=%0h be=%h want 1 1 3", mem_req, mem_we, mem_be); else n_pass++;
        n_chk++; if (mem_addr !== 32'h2004 || mem_wdata !== 32'hDEADBEEF) $display("FAIL store_fields: got addr=%h wdata=%h want 00002004 deadbeef", mem_addr, mem_wdata); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h99999999;
        settle;
        n_chk++; if (stall_mem !== 1'b1) $display("FAIL store_stall: got %0h want 1", stall_mem); else n_pass++;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (dm_ready !== 1'b1 || dm_rdata !== exp_dm) $display("FAIL store_ack: got ready=%0h rdata=%h want 1 %h", dm_ready, dm_rdata, exp_dm); else n_pass++;
        dm_req = 0; dm_we = 0;
        step;
    endtask

    task automatic test_kill;
        if_req = 1; if_addr = 32'h104; if_kill = 1;
        settle;
        n_chk++; if (mem_req !== 1'b0) $display("FAIL kill_idle_no_issue: got %0h want 0", mem_req); else n_pass++;
        step;
        if_kill = 0;
        settle;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) $display("FAIL kill_issue: got req=%0h addr=%h want 1 00000104", mem_req, mem_addr); else n_pass++;
        step;
        if_kill = 1;
        step;
        if_kill = 0; if_addr = 32'h200;
        mem_rvalid = 1; mem_rdata = 32'h0BAD0BAD;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (if_ready !== 1'b0 || if_rdata !== exp_if) $display("FAIL kill_dropped: got ready=%0h rdata=%h want 0 %h", if_ready, if_rdata, exp_if); else n_pass++;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) $display("FAIL kill_refetch: got req=%0h addr=%h want 1 00000200", mem_req, mem_addr); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h00000013;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (if_ready !== 1'b1 || if_rdata !== 32'h13) $display("FAIL kill_refetch_done: got ready=%0h rdata=%h want 1 00000013", if_ready, if_rdata); else n_pass++;
        if_req = 0;
        step;
        exp_if = 32'h13;
    endtask

    task automatic test_timeout;
        if_req = 1; if_addr = 32'h400;
        settle;
        n_chk++; if (mem_req !== 1'b1) $display("FAIL to_issue: got %0h want 1", mem_req); else n_pass++;
        step; step; step; step;
        settle;
        n_chk++; if (mem_err !== 1'b0 || if_ready !== 1'b0) $display("FAIL to_early: got err=%0h ready=%0h want 0 0", mem_err, if_ready); else n_pass++;
        step;
        n_chk++; if (mem_err !== 1'b1 || if_ready !== 1'b1) $display("FAIL to_abort: got err=%0h ready=%0h want 1 1", mem_err, if_ready); else n_pass++;
        n_chk++; if (if_rdata !== exp_if) $display("FAIL to_rdata_held: got %h want %h", if_rdata, exp_if); else n_pass++;
        if_req = 0;
        step;
        dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
        settle;
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) $display("FAIL to_next_issue: got req=%0h addr=%h want 1 00003000", mem_req, mem_addr); else n_pass++;
        step;
        mem_rvalid = 1; mem_rdata = 32'h66666666;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (dm_ready !== 1'b1 || dm_rdata !== 32'h66666666 || mem_err !== 1'b1) $display("FAIL to_sticky: got ready=%0h rdata=%h err=%0h want 1 66666666 1", dm_ready, dm_rdata, mem_err); else n_pass++;
        dm_req = 0;
        step;
    endtask

    task automatic test_rst_mid;
        dm_req = 1; dm_we = 0; dm_addr = 32'h3004;
        step;
        rst = 1; dm_req = 0;
        step;
        rst = 0;
        step;
        mem_rvalid = 1; mem_rdata = 32'h77777777;
        settle;
        n_chk++; if ({mem_req, dm_ready, if_ready, mem_err} !== 4'b0000) $display("FAIL rst_mid_flags: got req/dready/iready/err=%b want 0000", {mem_req, dm_ready, if_ready, mem_err}); else n_pass++;
        step;
        mem_rvalid = 0;
        settle;
        n_chk++; if (dm_ready !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) $display("FAIL rst_mid_stray: got ready=%0h drdata=%h irdata=%h want 0 0 0", dm_ready, dm_rdata, if_rdata); else n_pass++;
        step;
    endtask

    initial begin
        test_reset;
        test_fetch;
        test_tie;
        test_store;
        test_kill;
        test_timeout;
        test_rst_mid;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
